led_stream_tx: RTL and testbench

//  Serial WS2812-class LED-strip transmitter; downstream consumer of per-LED 24-bit colour words (rgb + data_v).

---
 rtl/led_stream_tx.sv | 194 +++++++++++++++++++
 tb/tb_led_stream_tx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_stream_tx.sv
// led_stream_tx: WS2812-class one-wire LED strip transmitter.
// Colour words are buffered in a small FIFO and sent NUM_LEDS per frame as NRZ
// pulses, MSB first. Each frame closes with a TRESET-cycle low latch interval.
// A frame that starves for GAP_MAX cycles between words is aborted (underflow_o).
// Build option: define LED_TX_GRB_ORDER_EN to send each word in {G,R,B} order
// (WS2812B wiring); when undefined the word goes out as {R,G,B}.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame in progress, waiting for a buffered word
// LOAD    | pop one word into the shifter (led low for this one cycle)
// HIGH    | led high for T0H or T1H cycles depending on shifter MSB
// LOW     | led low for the remainder of the TBIT bit period
// GAP     | mid-frame, FIFO empty; abort after GAP_MAX idle cycles
// LATCH   | led low for TRESET cycles so the strip latches the frame

module led_stream_tx #(
    parameter int NUM_LEDS   = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int TBIT       = 63,
    parameter int T0H        = 20,
    parameter int T1H        = 40,
    parameter int TRESET     = 3000,
    parameter int GAP_MAX    = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] rgb_i,
    input  logic        data_v_i,
    output logic        ready_o,
    output logic        led_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underflow_o
);

    localparam int TMAX_A = (TRESET > TBIT) ? TRESET : TBIT;
    localparam int TMAX   = (TMAX_A > GAP_MAX) ? TMAX_A : GAP_MAX;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int WCW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    // Timer reload values: the timer counts down and the state ends on zero.
    localparam logic [TW-1:0]  T0H_M1    = TW'(T0H - 1);
    localparam logic [TW-1:0]  T1H_M1    = TW'(T1H - 1);
    localparam logic [TW-1:0]  T0L_M1    = TW'(TBIT - T0H - 1);
    localparam logic [TW-1:0]  T1L_M1    = TW'(TBIT - T1H - 1);
    localparam logic [TW-1:0]  TRESET_M1 = TW'(TRESET - 1);
    localparam logic [TW-1:0]  GAP_M1    = TW'(GAP_MAX - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HIGH, S_LOW, S_GAP, S_LATCH
    } state_t;

    state_t         state;
    logic [23:0]    shifter;
    logic [4:0]     bit_cnt;
    logic [WCW-1:0] word_cnt;
    logic [TW-1:0]  timer;

    logic [23:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic [23:0]    rd_word;
    logic [23:0]    load_word;

    assign ready_o    = (count != CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = data_v_i && ready_o;
    assign pop        = (state == S_LOAD);
    assign busy_o     = (state != S_IDLE);
    assign rd_word    = mem[rd_ptr];

`ifdef LED_TX_GRB_ORDER_EN
    assign load_word  = {rd_word[15:8], rd_word[23:16], rd_word[7:0]};
`else
    assign load_word  = rd_word;
`endif

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rgb_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmit sequencer: bit timing, word/frame counting and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            shifter      <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            timer        <= '0;
            led_o        <= 1'b0;
            frame_done_o <= 1'b0;
            underflow_o  <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            underflow_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) state <= S_LOAD;
                end
                S_LOAD: begin
                    shifter <= load_word;
                    bit_cnt <= 5'd23;
                    timer   <= load_word[23] ? T1H_M1 : T0H_M1;
                    led_o   <= 1'b1;
                    state   <= S_HIGH;
                end
                S_HIGH: begin
                    if (timer == '0) begin
                        led_o <= 1'b0;
                        timer <= shifter[23] ? T1L_M1 : T0L_M1;
                        state <= S_LOW;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_LOW: begin
                    if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end else if (bit_cnt != 5'd0) begin
                        // Next bit's high time comes from the bit about to become MSB.
                        shifter <= {shifter[22:0], 1'b0};
                        bit_cnt <= bit_cnt - 5'd1;
                        timer   <= shifter[22] ? T1H_M1 : T0H_M1;
                        led_o   <= 1'b1;
                        state   <= S_HIGH;
                    end else if (word_cnt == LAST_WORD) begin
                        word_cnt     <= '0;
                        timer        <= TRESET_M1;
                        frame_done_o <= (TRESET == 1);
                        state        <= S_LATCH;
                    end else begin
                        word_cnt <= word_cnt + WCW'(1);
                        if (!fifo_empty) begin
                            state <= S_LOAD;
                        end else begin
                            timer <= GAP_M1;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (!fifo_empty) begin
                        state <= S_LOAD;
                    end else if (timer == '0) begin
                        underflow_o <= 1'b1;
                        word_cnt    <= '0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_LATCH: begin
                    // frame_done_o is registered so it lands on the final latch cycle.
                    if (timer == '0) begin
                        state <= S_IDLE;
                    end else begin
                        timer        <= timer - TW'(1);
                        frame_done_o <= (timer == TW'(1));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_stream_tx.sv
// tb_led_stream_tx: scoreboard bench for led_stream_tx.
// Stimulus pushes the expected transmitted word into a queue when a word is
// accepted; a monitor decodes led_o pulses into words and compares them.
// Compile with LED_TX_GRB_ORDER_EN defined to exercise the {G,R,B} build.

module tb_led_stream_tx;

    localparam int NUM_LEDS   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TBIT       = 10;
    localparam int T0H        = 3;
    localparam int T1H        = 6;
    localparam int TRESET     = 20;
    localparam int GAP_MAX    = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] rgb_i;
    logic        data_v_i;
    logic        ready_o;
    logic        led_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        underflow_o;

    led_stream_tx #(
        .NUM_LEDS  (NUM_LEDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .TBIT      (TBIT),
        .T0H       (T0H),
        .T1H       (T1H),
        .TRESET    (TRESET),
        .GAP_MAX   (GAP_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rgb_i       (rgb_i),
        .data_v_i    (data_v_i),
        .ready_o     (ready_o),
        .led_o       (led_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q [$];

    // monitor state
    int          rises = 0;
    int          last_rise = 0;
    int          nbits = 0;
    int          words_in_frame = 0;
    int          fd_cnt = 0;
    int          uf_cnt = 0;
    bit          busy_pending = 0;
    bit          b2b_mode = 0;
    logic        prev_led = 1'b0;
    logic [23:0] cur_word = '0;
    logic [23:0] exp_word;
    int          hl;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Strip wiring order: the model states what should appear on the wire.
    function automatic logic [23:0] wire_word(input logic [23:0] w);
`ifdef LED_TX_GRB_ORDER_EN
        return {w[15:8], w[23:16], w[7:0]};
`else
        return w;
`endif
    endfunction

    // Monitor: decode pulses into bits and words, check timing and events.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_led       = 1'b0;
            nbits          = 0;
            words_in_frame = 0;
            busy_pending   = 0;
        end else begin
            if (busy_pending) begin
                chk("busy_after_frame_done", busy_o, 1'b0);
                busy_pending = 0;
            end
            if (led_o && !prev_led) begin
                if (nbits > 0)
                    chk("bit_period", cyc - last_rise, TBIT);
                else if (words_in_frame > 0 && b2b_mode)
                    chk("word_boundary_period", cyc - last_rise, TBIT + 1);
                last_rise = cyc;
                rises++;
            end
            if (!led_o && prev_led) begin
                hl = cyc - last_rise;
                chk("pulse_width_legal", (hl == T0H || hl == T1H), 1'b1);
                cur_word = {cur_word[22:0], (hl == T1H)};
                nbits++;
                if (nbits == 24) begin
                    nbits = 0;
                    words_in_frame++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %06h, expected none", cur_word);
                    end else begin
                        exp_word = exp_q.pop_front();
                        chk("word", cur_word, exp_word);
                    end
                end
            end
            if (frame_done_o) begin
                fd_cnt++;
                chk("latch_length", cyc - last_rise, TBIT + TRESET - 1);
                chk("frame_word_count", words_in_frame, NUM_LEDS);
                words_in_frame = 0;
                busy_pending   = 1;
            end
            if (underflow_o) begin
                uf_cnt++;
                chk("gap_length", cyc - last_rise, TBIT + GAP_MAX);
                chk("busy_after_underflow", busy_o, 1'b0);
                words_in_frame = 0;
            end
            prev_led = led_o;
        end
    end

    task automatic wait_until_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle word presentation; the model decides whether it is accepted.
    task automatic drive_word(input logic [23:0] w, input bit accept, output int acc_cyc);
        rgb_i    = w;
        data_v_i = 1'b1;
        @(posedge clk);
        if (accept) exp_q.push_back(wire_word(w));
        #1;
        acc_cyc  = cyc;
        data_v_i = 1'b0;
    endtask

    task automatic wait_rises(input int target, input int budget);
        int c = 0;
        while (rises < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (rises < target) fail("wait_rises");
    endtask

    task automatic wait_fd(input int target, input int budget);
        int c = 0;
        while (fd_cnt < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (fd_cnt < target) fail("wait_frame_done");
    endtask

    task automatic wait_uf(input int target, input int budget);
        int c = 0;
        while (uf_cnt < target && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (uf_cnt < target) fail("wait_underflow");
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((busy_o || exp_q.size() != 0) && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, fd0, uf0, r;
        logic [23:0] w [6];

        rst_n    = 1'b1;
        rgb_i    = '0;
        data_v_i = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", led_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_ready", ready_o, 1'b1);
        chk("reset_frame_done", frame_done_o, 1'b0);
        chk("reset_underflow", underflow_o, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Fixed pattern: red then black, back-to-back, with start latency check.
        b2b_mode = 1;
        fd0 = fd_cnt; uf0 = uf_cnt; r = rises;
        drive_word(24'hFF0000, 1'b1, k);
        drive_word(24'h000000, 1'b1, k2);
        wait_rises(r + 1, 50);
        chk("start_latency", last_rise - k, 2);
        wait_fd(fd0 + 1, 2000);
        wait_idle(200);
        chk("t1_frames", fd_cnt - fd0, 1);
        chk("t1_underflows", uf_cnt - uf0, 0);
        b2b_mode = 0;

        // Random frames with small random gaps between the two words.
        for (int f = 0; f < 3; f++) begin
            fd0 = fd_cnt; uf0 = uf_cnt;
            drive_word(24'($urandom), 1'b1, k);
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            drive_word(24'($urandom), 1'b1, k);
            wait_fd(fd0 + 1, 2000);
            wait_idle(200);
            chk("rand_frames", fd_cnt - fd0, 1);
            chk("rand_underflows", uf_cnt - uf0, 0);
        end

        // Overfill during LATCH: four accepted, the rest dropped.
        b2b_mode = 1;
        fd0 = fd_cnt; uf0 = uf_cnt; r = rises;
        drive_word(24'($urandom), 1'b1, k);
        drive_word(24'($urandom), 1'b1, k);
        wait_rises(r + 48, 2000);
        wait_until_cyc(last_rise + 12);
        for (int i = 0; i < 6; i++) begin
            w[i] = 24'($urandom_range(0, 24'hFFFFFF)) ^ 24'(i);
            chk("ready_fill", ready_o, (i < FIFO_DEPTH) ? 1'b1 : 1'b0);
            drive_word(w[i], (i < FIFO_DEPTH), k);
        end
        wait_fd(fd0 + 3, 4000);
        wait_idle(200);
        chk("t3_frames", fd_cnt - fd0, 3);
        chk("t3_underflows", uf_cnt - uf0, 0);
        b2b_mode = 0;

        // Starvation: single word then abort; next frame starts from word 0.
        fd0 = fd_cnt; uf0 = uf_cnt;
        drive_word(24'($urandom), 1'b1, k);
        wait_uf(uf0 + 1, 2000);
        wait_idle(200);
        chk("t4_underflows", uf_cnt - uf0, 1);
        chk("t4_no_frame_done", fd_cnt - fd0, 0);
        fd0 = fd_cnt; uf0 = uf_cnt;
        drive_word(24'($urandom), 1'b1, k);
        drive_word(24'($urandom), 1'b1, k);
        wait_fd(fd0 + 1, 2000);
        wait_idle(200);
        chk("t4_restart_frames", fd_cnt - fd0, 1);
        chk("t4_restart_underflows", uf_cnt - uf0, 0);

        // Word arriving during GAP rescues the frame.
        fd0 = fd_cnt; uf0 = uf_cnt; r = rises;
        drive_word(24'($urandom), 1'b1, k);
        wait_rises(r + 24, 1000);
        wait_until_cyc(last_rise + 13);
        drive_word(24'($urandom), 1'b1, k);
        wait_fd(fd0 + 1, 2000);
        wait_idle(200);
        chk("t5_frames", fd_cnt - fd0, 1);
        chk("t5_underflows", uf_cnt - uf0, 0);

        // Asynchronous reset in the middle of a high pulse.
        r = rises;
        drive_word(24'($urandom), 1'b1, k);
        wait_rises(r + 1, 50);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_led", led_o, 1'b0);
        chk("async_reset_busy", busy_o, 1'b0);
        chk("async_reset_ready", ready_o, 1'b1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fd0 = fd_cnt; uf0 = uf_cnt; r = rises;
        drive_word(24'($urandom), 1'b1, k);
        drive_word(24'($urandom), 1'b1, k2);
        wait_rises(r + 1, 50);
        chk("post_reset_latency", last_rise - k, 2);
        wait_fd(fd0 + 1, 2000);
        wait_idle(200);
        chk("t6_frames", fd_cnt - fd0, 1);
        chk("t6_underflows", uf_cnt - uf0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
